// File: rtl/sys_bus_pkg.sv
// Shared types and helpers for the 65xx bus fabric: bus merge mode,
// RDY state encoding, lowest-index one-hot pick and population count.
package sys_bus_pkg;

    // Widest slave vector the helpers accept; callers zero-extend into it.
    localparam int MAX_SLAVES = 32;

    typedef enum logic {
        BUS_AND = 1'b0,
        BUS_MUX = 1'b1
    } bus_mode_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        TOUT  = 2'd2
    } rdy_state_e;

    // Keep only the lowest set bit (two's-complement isolate).
    function automatic logic [MAX_SLAVES-1:0] prio_onehot(input logic [MAX_SLAVES-1:0] v);
        return v & (~v + MAX_SLAVES'(1));
    endfunction

    // Number of set bits, 0..MAX_SLAVES.
    function automatic logic [5:0] popcount(input logic [MAX_SLAVES-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bus_phase_gen.sv
// Phase generator: a free-running 0..CLK_DIV-1 counter produces a one-clock
// phi0 enable, and the same pulse delayed PH2_OFS clocks becomes phi2.
module bus_phase_gen #(
    parameter int CLK_DIV = 3,
    parameter int PH2_OFS = 2
) (
    input  logic clk,
    input  logic rst,
    output logic cpu_en,
    output logic ph2
);

    localparam int PH_W = $clog2(CLK_DIV);

    logic [PH_W-1:0]    cnt;
    logic [PH2_OFS-1:0] en_dly;

    // Phase counter and phi0 enable on the last phase of each CPU cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            cpu_en <= 1'b0;
        end else begin
            cnt    <= (cnt == PH_W'(CLK_DIV - 1)) ? '0 : cnt + PH_W'(1);
            cpu_en <= (cnt == PH_W'(CLK_DIV - 1));
        end
    end

    // Delay line from phi0; deriving phi2 from it avoids a spurious pulse before the first phi0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_dly <= '0;
        end else begin
            en_dly <= (en_dly << 1) | PH2_OFS'(cpu_en);
        end
    end

    assign ph2 = en_dly[PH2_OFS-1];

endmodule

// File: rtl/sys_bus_fabric.sv
// CPU-side bus fabric for 65xx systems: clock enables, address decode to
// one-hot slave selects, read-data merge into a registered cpu_di, and RDY
// generation from slave stall requests with an optional stall timeout.
// Optional macro BUS_DECODE_CHECK_EN builds the unmapped/overlap decode
// checkers; without it err_unmapped and err_overlap are tied low.
//
// RDY handshake: slaves raise slv_stall before a phi2 strobe; the fabric samples
// it only on phi2 clocks and drops cpu_rdy from the following clock until a phi2
// sees stall low (or the timeout fires). While cpu_rdy is low the CPU must not
// complete its current cycle; cpu_di only updates on phi2 read clocks.
module sys_bus_fabric import sys_bus_pkg::*; #(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 3,
    parameter int PH2_OFS    = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK  = {13'h1000, 13'h1080, 13'h1080},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MATCH = {13'h1000, 13'h0080, 13'h0000},
    parameter int MODE       = 0,
    parameter int TIMEOUT    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic                         cpu_rw_n,
    output logic [DATA_W-1:0]            cpu_di,
    output logic                         cpu_en,
    output logic                         ph2,
    output logic                         cpu_rdy,
    output logic [NUM_SLAVES-1:0]        slv_sel,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]        slv_stall,
    input  logic                         err_clr,
    output logic                         err_timeout,
    output logic                         err_unmapped,
    output logic                         err_overlap
);

    localparam bus_mode_e MODE_E = (MODE == 1) ? BUS_MUX : BUS_AND;
    localparam int        CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [NUM_SLAVES-1:0] raw;
    logic [DATA_W-1:0]     rd_and;
    logic [DATA_W-1:0]     rd_mux;
    logic [DATA_W-1:0]     rd_next;
    logic                  stall;
    logic                  tout_set;
    rdy_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;

    bus_phase_gen #(
        .CLK_DIV (CLK_DIV),
        .PH2_OFS (PH2_OFS)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .cpu_en (cpu_en),
        .ph2    (ph2)
    );

    // Raw per-slave address match against mask/match windows.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            raw[i] = ((cpu_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_MATCH[i*ADDR_W +: ADDR_W]);
        end
    end

    // Lowest-index match wins; no match gives an all-zero select.
    assign slv_sel = NUM_SLAVES'(prio_onehot(MAX_SLAVES'(raw)));

    // Read-data merge: wired-AND of every slave, or the selected slave with open-bus hold.
    always_comb begin
        rd_and = '1;
        rd_mux = cpu_di;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rd_and = rd_and & slv_rdata[i*DATA_W +: DATA_W];
            if (slv_sel[i]) begin
                rd_mux = slv_rdata[i*DATA_W +: DATA_W];
            end
        end
        rd_next = (MODE_E == BUS_MUX) ? rd_mux : rd_and;
    end

    // CPU read-data register, loaded only on phi2 read clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_di <= '1;
        end else if (ph2 && cpu_rw_n) begin
            cpu_di <= rd_next;
        end
    end

    assign stall   = |slv_stall;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // RDY next-state: stall sampled on phi2 only; the counter saturates instead of wrapping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tout_set = 1'b0;
        if (ph2) begin
            case (state_q)
                RUN: begin
                    if (stall) begin
                        state_d = STALL;
                        cnt_d   = '0;
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_inc;
                        if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
                            state_d  = TOUT;
                            tout_set = 1'b1;
                        end
                    end
                end
                TOUT: begin
                    if (!stall) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // RDY state and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_rdy = (state_q != STALL);

    // Sticky timeout flag; a set in the same clock as err_clr takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (tout_set) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

`ifdef BUS_DECODE_CHECK_EN
    logic [5:0] hit_cnt;

    assign hit_cnt = popcount(MAX_SLAVES'(raw));

    // Sticky decode-check flags, evaluated on phi2 clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unmapped <= 1'b0;
            err_overlap  <= 1'b0;
        end else begin
            if (ph2 && (hit_cnt == 6'd0)) begin
                err_unmapped <= 1'b1;
            end else if (err_clr) begin
                err_unmapped <= 1'b0;
            end
            if (ph2 && (hit_cnt > 6'd1)) begin
                err_overlap <= 1'b1;
            end else if (err_clr) begin
                err_overlap <= 1'b0;
            end
        end
    end
`else
    assign err_unmapped = 1'b0;
    assign err_overlap  = 1'b0;
`endif

endmodule
